// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control FSM with memory-handshake watchdog
//
// Purpose: sequences fetch/decode/execute/memory/write-back for the single-memory
// datapath and drives the immediate extender, register file, ALU mux, PC and memory
// strobes. A watchdog parks the core in FAULT when mem_ready never answers mem_req.
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN (adds cyc_cnt / ret_cnt).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   instr[31:0]       memory read data, loaded into IR on fetch completion
//   mem_ready         memory access completes in a cycle with mem_req && mem_ready
//   mem_req, mem_we   memory request / store qualifier
//   addr_sel          0 = PC address, 1 = ALU result address
//   ir_we, pc_we      IR and PC write enables
//   pc_src            0 = PC+1, 1 = jump target
//   imm[25:0]         immediate field for ext_module
//   imm_ctrl[1:0]     00 zero-ext 13b, 01 sign-ext 13b, 10 ext 26b
//   alu_src           0 = register B, 1 = extended immediate
//   reg_we, wb_sel    register write enable, 0 = ALU / 1 = memory write-back data
//   halted, fault     sticky status until rst
//   cyc_cnt, ret_cnt  (perf build only) cycle and retired-instruction counters

module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic [25:0] imm,
  output logic [1:0]  imm_ctrl,
  output logic        alu_src,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        halted,
  output logic        fault
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt
`endif
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CLS_R   = 2'b00;
  localparam logic [1:0] CLS_I   = 2'b01;
  localparam logic [1:0] CLS_J   = 2'b10;
  localparam logic [1:0] CLS_MEM = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_FAULT
  } state_t;

  state_t          state, state_nxt;
  logic [31:0]     ir;
  logic [WD_W-1:0] wd_cnt;
  logic [1:0]      cls;
  logic            is_halt;
  logic            is_store;
  logic            wd_last;
  logic            retire;

  assign cls      = ir[31:30];
  assign is_halt  = (ir == 32'hFFFF_FFFF);
  assign is_store = ir[29];
  // This wait cycle would be the TIMEOUT-th unanswered one.
  assign wd_last  = (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_FETCH;
      ir     <= '0;
      wd_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (ir_we) ir <= instr;
      // Any state change (entry to FETCH/MEM included) restarts the count.
      if (state_nxt != state)
        wd_cnt <= '0;
      else if (mem_req && !mem_ready)
        wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    imm       = '0;
    imm_ctrl  = 2'b00;
    alu_src   = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    retire    = 1'b0;

    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          state_nxt = ST_DECODE;
        end else if (wd_last) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_DECODE: state_nxt = is_halt ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        alu_src = (cls == CLS_I) || (cls == CLS_MEM);
        case (cls)
          CLS_J: begin
            pc_we     = 1'b1;
            pc_src    = 1'b1;
            retire    = 1'b1;
            state_nxt = ST_FETCH;
          end
          CLS_MEM: state_nxt = ST_MEM;
          default: state_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        if (mem_ready) begin
          retire    = is_store;
          state_nxt = is_store ? ST_FETCH : ST_WB;
        end else if (wd_last) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_WB: begin
        reg_we    = 1'b1;
        wb_sel    = (cls == CLS_MEM);
        retire    = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_HALT:  halted = 1'b1;
      ST_FAULT: fault  = 1'b1;
      default:  state_nxt = ST_FETCH;
    endcase

    // Immediate is held from DECODE until the next FETCH.
    if (state == ST_DECODE || state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
      case (cls)
        CLS_I: begin
          imm      = {13'b0, ir[12:0]};
          imm_ctrl = is_store ? 2'b01 : 2'b00;
        end
        CLS_MEM: begin
          imm      = {13'b0, ir[12:0]};
          imm_ctrl = 2'b01;
        end
        CLS_J: begin
          imm      = ir[25:0];
          imm_ctrl = 2'b10;
        end
        default: begin
          imm      = '0;
          imm_ctrl = 2'b00;
        end
      endcase
    end

    // The state register only resets at the edge, so outputs are blanked
    // combinationally for the whole reset cycle; this also aborts any access.
    if (rst) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_src   = 1'b0;
      imm      = '0;
      imm_ctrl = 2'b00;
      alu_src  = 1'b0;
      reg_we   = 1'b0;
      wb_sel   = 1'b0;
      halted   = 1'b0;
      fault    = 1'b0;
      retire   = 1'b0;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (state != ST_HALT && state != ST_FAULT) cyc_cnt <= cyc_cnt + 1'b1;
      if (retire) ret_cnt <= ret_cnt + 1'b1;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl

module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src;
  logic [25:0] imm;
  logic [1:0]  imm_ctrl;
  logic        alu_src, reg_we, wb_sel, halted, fault;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .mem_ready(mem_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .addr_sel (addr_sel),
    .ir_we    (ir_we),
    .pc_we    (pc_we),
    .pc_src   (pc_src),
    .imm      (imm),
    .imm_ctrl (imm_ctrl),
    .alu_src  (alu_src),
    .reg_we   (reg_we),
    .wb_sel   (wb_sel),
    .halted   (halted),
    .fault    (fault)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cyc_cnt  (cyc_cnt),
    .ret_cnt  (ret_cnt)
`endif
  );

  // {mem_req,mem_we,addr_sel,ir_we,pc_we,pc_src,alu_src,reg_we,wb_sel,halted,fault}
  logic [10:0] v;
  assign v = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src, reg_we, wb_sel, halted, fault};

  localparam logic [10:0] V_IDLE    = 11'b00000000000;
  localparam logic [10:0] V_FETCH_R = 11'b10011000000;
  localparam logic [10:0] V_FETCH_W = 11'b10000000000;
  localparam logic [10:0] V_EXEC_I  = 11'b00000010000;
  localparam logic [10:0] V_EXEC_J  = 11'b00001100000;
  localparam logic [10:0] V_WB_ALU  = 11'b00000001000;
  localparam logic [10:0] V_WB_LD   = 11'b00000001100;
  localparam logic [10:0] V_MEM_LD  = 11'b10100000000;
  localparam logic [10:0] V_MEM_ST  = 11'b11100000000;
  localparam logic [10:0] V_HALT    = 11'b00000000010;
  localparam logic [10:0] V_FAULT   = 11'b00000000001;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Ends one time unit after the release, i.e. in FETCH cycle 1.
  task automatic do_reset(input logic [31:0] first_instr, input logic ready);
    rst       = 1'b1;
    mem_ready = 1'b0;
    cyc();
    cyc();
    check("rst_strobes", v, V_IDLE);
    check("rst_imm", {imm_ctrl, imm}, 28'h0);
    rst       = 1'b0;
    instr     = first_instr;
    mem_ready = ready;
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    instr     = 32'h0;
    mem_ready = 1'b0;

    // I-ALU signed
    do_reset(32'h6000_1FFF, 1'b1);
    check("i_s_fetch", v, V_FETCH_R);
    cyc();
    check("i_s_dec", v, V_IDLE);
    check("i_s_imm", imm, 26'h1FFF);
    check("i_s_ctrl", imm_ctrl, 2'b01);
    cyc();
    check("i_s_exec", v, V_EXEC_I);
    cyc();
    check("i_s_wb_c4", v, V_WB_ALU);
    check("i_s_imm_wb", imm, 26'h1FFF);
    cyc();
    check("i_s_next_fetch", v, V_FETCH_R);

    // I-ALU unsigned
    do_reset(32'h4000_0003, 1'b1);
    cyc();
    check("i_u_imm", imm, 26'h3);
    check("i_u_ctrl", imm_ctrl, 2'b00);

    // Jump
    do_reset(32'h83FF_FFFF, 1'b1);
    cyc();
    check("j_imm", imm, 26'h3FF_FFFF);
    check("j_ctrl", imm_ctrl, 2'b10);
    cyc();
    check("j_exec_c3", v, V_EXEC_J);
    cyc();
    check("j_back_fetch", v, V_FETCH_R);

    // Load with mem_ready delayed three cycles in MEM
    do_reset(32'hC000_0010, 1'b1);
    cyc();
    check("ld_imm", {imm_ctrl, imm}, {2'b01, 26'h10});
    cyc();
    check("ld_exec", v, V_EXEC_I);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("ld_mem_wait", v, V_MEM_LD);
    end
    cyc();
    mem_ready = 1'b1;
    #1;
    check("ld_mem_4th", v, V_MEM_LD);
    cyc();
    check("ld_wb", v, V_WB_LD);
    cyc();
    check("ld_next_fetch", v, V_FETCH_R);

    // Store
    do_reset(32'hE000_0010, 1'b1);
    cyc();
    cyc();
    check("st_exec", v, V_EXEC_I);
    cyc();
    check("st_mem", v, V_MEM_ST);
    cyc();
    check("st_no_wb", v, V_FETCH_R);

    // Watchdog expiry in FETCH
    do_reset(32'h0000_0000, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check("wd_wait", v, V_FETCH_W);
      cyc();
    end
    check("wd_fault", v, V_FAULT);
    mem_ready = 1'b1;
    cyc();
    cyc();
    check("wd_fault_sticky", v, V_FAULT);

    // Ready on the 16th wait cycle wins
    do_reset(32'h0000_0000, 1'b0);
    for (int i = 0; i < 15; i++) cyc();
    mem_ready = 1'b1;
    #1;
    check("wd_edge_fetch", v, V_FETCH_R);
    cyc();
    check("wd_edge_dec", v, V_IDLE);
    cyc();
    check("wd_edge_r_exec", v, V_IDLE);
    cyc();
    check("wd_edge_r_wb", v, V_WB_ALU);

    // HALT
    do_reset(32'hFFFF_FFFF, 1'b1);
    cyc();
    check("halt_dec", v, V_IDLE);
    for (int i = 0; i < 20; i++) begin
      cyc();
      mem_ready = i[0];
      check("halt_hold", v, V_HALT);
    end
    rst = 1'b1;
    #1;
    check("halt_rst_cycle", v, V_IDLE);
    cyc();
    rst = 1'b0;
    mem_ready = 1'b1;
    instr = 32'h0000_0000;
    #1;
    check("halt_rst_fetch", v, V_FETCH_R);

    // Reset during MEM wait
    do_reset(32'hC000_0010, 1'b1);
    cyc();
    cyc();
    mem_ready = 1'b0;
    cyc();
    check("rm_mem", v, V_MEM_LD);
    cyc();
    rst = 1'b1;
    #1;
    check("rm_rst_out", v, V_IDLE);
    check("rm_rst_imm", {imm_ctrl, imm}, 28'h0);
    mem_ready = 1'b1;
    #1;
    check("rm_rst_ready", v, V_IDLE);
    cyc();
    check("rm_rst_hold", v, V_IDLE);
    rst = 1'b0;
    #1;
    check("rm_after_fetch", v, V_FETCH_R);

`ifdef MULTICYCLE_CTRL_PERF_EN
    // R, I, store: 4 cycles each, three retirements
    do_reset(32'h0000_0000, 1'b1);
    check("perf_rst_cyc", cyc_cnt, 32'd0);
    check("perf_rst_ret", ret_cnt, 32'd0);
    for (int i = 0; i < 4; i++) cyc();
    instr = 32'h4000_0003;
    for (int i = 0; i < 4; i++) cyc();
    instr = 32'hE000_0010;
    for (int i = 0; i < 4; i++) cyc();
    check("perf_ret3", ret_cnt, 32'd3);
    check("perf_cyc12", cyc_cnt, 32'd12);
    rst = 1'b1;
    cyc();
    check("perf_clr_cyc", cyc_cnt, 32'd0);
    check("perf_clr_ret", ret_cnt, 32'd0);
    rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
